// File: rtl/dff_ram_banked.sv
// dff_ram_banked: banked flip-flop RAM with byte-masked writes, registered read, range error and post-reset clear
module dff_ram_banked #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 8,
  parameter int BANKS = 2,
  parameter int BYTE_W = 8,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_n,
  input  logic [AW-1:0]           address,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [WIDTH/BYTE_W-1:0] wmask,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid,
  output logic                    busy,
  output logic                    err
);
  localparam int BD = DEPTH / BANKS;
  localparam int RW = BD > 1 ? $clog2(BD) : 1;
  localparam int LANES = WIDTH / BYTE_W;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [RW-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic acc, in_range, wr_acc, rd_acc;
  if (BANKS < 1 || (BANKS & (BANKS - 1)) != 0 || WIDTH % BYTE_W != 0 || DEPTH % BANKS != 0) begin : g_bad
    $fatal(1, "dff_ram_banked: illegal WIDTH/DEPTH/BANKS/BYTE_W combination");
  end
  assign in_range = 32'(address) < 32'(DEPTH);
  assign acc = en && state == IDLE && !rst;
  assign wr_acc = acc && !wr_n && in_range;
  assign rd_acc = acc && wr_n && in_range;
  assign busy = state == CLEAR;
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk)
      if (!rst && busy && cnt == RW'(i % BD))
        mem[i] <= '0;
      else if (wr_acc && address == AW'(i))
        for (int l = 0; l < LANES; l++)
          if (wmask[l])
            mem[i][l*BYTE_W +: BYTE_W] <= wdata[l*BYTE_W +: BYTE_W];
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      err <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      err <= acc && !in_range;
      if (rd_acc)
        rdata <= mem[address];
      if (busy) begin
        cnt <= cnt + 1'b1;
        if (cnt == RW'(BD - 1))
          state <= IDLE;
      end
    end
endmodule
